// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared FSM state type for the divider scheduler.
package div_sched_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first request at or above ptr with wrap.
module rr_arbiter #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] ptr,
  output logic [R-1:0]         grant
);
  // Scan farthest-to-nearest so the request closest to ptr wins the last write.
  always_comb begin
    grant = '0;
    for (int k = R - 1; k >= 0; k--)
      grant = req[(int'(ptr) + k) % R] ? R'(1) << ((int'(ptr) + k) % R) : grant;
  end
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin shared N-cycle restoring divider for R requesters.
// Optional DIV_SCHEDULER_DBZ_EN: divide-by-zero short-circuit with resp_dbz flag.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int R = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_valid,
  input  logic [R*N-1:0]       req_x,
  input  logic [R*N-1:0]       req_y,
  output logic [R-1:0]         req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [$clog2(R)-1:0] resp_id,
  output logic [N-1:0]         resp_quot,
  output logic [N-1:0]         resp_rem,
  output logic                 resp_dbz
);
  localparam int W = $clog2(R);
  localparam int CW = $clog2(N);
  state_t state;
  logic [W-1:0] rr_ptr, gidx, id;
  logic [CW-1:0] cnt;
  logic [N-1:0] y, rem, quot, rem_n, quot_n, gx, gy;
  logic [R-1:0] grant;
  logic [N:0] tmp;
  logic [N+1:0] sub;
  rr_arbiter #(.R(R)) u_arb (.req(req_valid), .ptr(rr_ptr), .grant(grant));
  always_comb begin
    gidx = '0;
    for (int k = 0; k < R; k++)
      gidx = gidx | (grant[k] ? W'(k) : '0);
  end
  assign req_ready = (state == IDLE) ? grant : '0;
  assign gx = req_x[gidx*N +: N];
  assign gy = req_y[gidx*N +: N];
  // Extra borrow bit beyond the N+1-bit trial value keeps large operands from aliasing.
  assign tmp = {rem, quot[N-1]};
  assign sub = {1'b0, tmp} - {2'b00, y};
  assign rem_n = sub[N+1] ? tmp[N-1:0] : sub[N-1:0];
  assign quot_n = {quot[N-2:0], ~sub[N+1]};
`ifndef DIV_SCHEDULER_DBZ_EN
  assign resp_dbz = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      id <= '0;
      y <= '0;
      rem <= '0;
      quot <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_quot <= '0;
      resp_rem <= '0;
`ifdef DIV_SCHEDULER_DBZ_EN
      resp_dbz <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (|req_ready) begin
        id <= gidx;
        rr_ptr <= (gidx == W'(R - 1)) ? '0 : gidx + 1'b1;
        rem <= '0;
        quot <= gx;
        y <= gy;
        cnt <= '0;
`ifdef DIV_SCHEDULER_DBZ_EN
        if (gy == '0) begin
          state <= DONE;
          resp_valid <= 1'b1;
          resp_id <= gidx;
          resp_quot <= '1;
          resp_rem <= gx;
          resp_dbz <= 1'b1;
        end else
          state <= BUSY;
`else
        state <= BUSY;
`endif
      end
    end else if (state == BUSY) begin
      rem <= rem_n;
      quot <= quot_n;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(N - 1)) begin
        state <= DONE;
        cnt <= '0;
        resp_valid <= 1'b1;
        resp_id <= id;
        resp_quot <= quot_n;
        resp_rem <= rem_n;
`ifdef DIV_SCHEDULER_DBZ_EN
        resp_dbz <= 1'b0;
`endif
      end
    end else if (resp_ready) begin
      state <= IDLE;
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: scoreboard bench for div_scheduler (N=8, R=4).
module tb_div_scheduler;
  localparam int N = 8;
  localparam int R = 4;
`ifdef DIV_SCHEDULER_DBZ_EN
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif
  typedef struct packed {
    logic [1:0]   id;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, resp_ready = 1'b1;
  logic [R-1:0] req_valid = '0;
  logic [R*N-1:0] req_x = '0, req_y = '0;
  logic [R-1:0] req_ready;
  logic resp_valid, resp_dbz;
  logic [1:0] resp_id;
  logic [N-1:0] resp_quot, resp_rem;
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  div_scheduler #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dbz(resp_dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(int i, int x, int y);
    exp_t e;
    e.id = 2'(i);
    e.q = (y == 0) ? '1 : N'(x / y);
    e.r = (y == 0) ? N'(x) : N'(x % y);
    e.dbz = (y == 0) && DBZ;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && resp_valid && resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got id=%0d quot=%0d rem=%0d dbz=%0d", resp_id, resp_quot, resp_rem, resp_dbz);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_id, resp_quot, resp_rem, resp_dbz} !== mon_e) begin
          failures++;
          $display("FAIL resp_data got id=%0d quot=%0d rem=%0d dbz=%0d exp id=%0d quot=%0d rem=%0d dbz=%0d",
                   resp_id, resp_quot, resp_rem, resp_dbz, mon_e.id, mon_e.q, mon_e.r, mon_e.dbz);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, int x, int y);
    req_x[i*N +: N] = N'(x);
    req_y[i*N +: N] = N'(y);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_dbz} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b id=%0d quot=%0d rem=%0d dbz=%b exp all 0",
               req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_dbz);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    int n;
    tick();
    set_req(2, 100, 7);
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got %b exp 0100", req_ready);
    end
    sb.push_back(model(2, 100, 7));
    tick();
    req_valid = '0;
    wait_resp(n);
    checks++;
    if (n !== N + 1) begin
      failures++;
      $display("FAIL single_latency got %0d exp %0d", n, N + 1);
    end
    checks++;
    if ({resp_id, resp_quot, resp_rem} !== {2'd2, 8'd14, 8'd2}) begin
      failures++;
      $display("FAIL single_result got id=%0d quot=%0d rem=%0d exp id=2 quot=14 rem=2", resp_id, resp_quot, resp_rem);
    end
    tick();
  endtask

  task automatic test_fairness();
    int n;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < R; i++) set_req(i, 200 - 37 * i, i + 3);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== R'(1 << (g % R))) begin
        failures++;
        $display("FAIL fair_grant%0d got %b exp %b", g, req_ready, R'(1 << (g % R)));
      end
      sb.push_back(model(g % R, 200 - 37 * (g % R), g % R + 3));
      wait_resp(n);
      checks++;
      if (!resp_valid) begin
        failures++;
        $display("FAIL fair_timeout%0d got no resp_valid exp resp_valid=1", g);
      end
      if (g == 4) req_valid = '0;
    end
    tick();
  endtask

  task automatic test_back_pressure();
    int n;
    bit bad;
    logic [18:0] snap;
    tick();
    set_req(1, 200, 9);
    set_req(3, 77, 5);
    req_valid = 4'b0010;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant got %b exp 0010", req_ready);
    end
    sb.push_back(model(1, 200, 9));
    tick();
    req_valid = 4'b1000;
    bad = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (req_ready !== '0) bad = 1'b1;
    end while (!resp_valid && n < 40);
    snap = {resp_id, resp_quot, resp_rem, resp_dbz};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!resp_valid || {resp_id, resp_quot, resp_rem, resp_dbz} !== snap || req_ready !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got unstable resp or req_ready=%b exp stable resp and req_ready=0", req_ready);
    end
    checks++;
    if (snap !== model(1, 200, 9)) begin
      failures++;
      $display("FAIL bp_data got %h exp %h", snap, model(1, 200, 9));
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_idle got %b exp 1000", req_ready);
    end
    sb.push_back(model(3, 77, 5));
    tick();
    req_valid = '0;
    wait_resp(n);
    tick();
  endtask

  task automatic test_boundary();
    int n;
    int bx[3] = '{255, 3, 255};
    int by[3] = '{1, 255, 255};
    int bq[3] = '{255, 0, 1};
    int br[3] = '{0, 3, 0};
    for (int c = 0; c < 3; c++) begin
      tick();
      set_req(0, bx[c], by[c]);
      req_valid = 4'b0001;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!req_ready[0] && n < 10);
      sb.push_back(model(0, bx[c], by[c]));
      tick();
      req_valid = '0;
      wait_resp(n);
      checks++;
      if (!resp_valid || resp_quot !== N'(bq[c]) || resp_rem !== N'(br[c])) begin
        failures++;
        $display("FAIL boundary%0d got valid=%b quot=%0d rem=%0d exp quot=%0d rem=%0d",
                 c, resp_valid, resp_quot, resp_rem, bq[c], br[c]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int n;
    tick();
    set_req(1, 42, 0);
    req_valid = 4'b0010;
    @(negedge clk);
    sb.push_back(model(1, 42, 0));
    tick();
    req_valid = '0;
    wait_resp(n);
    checks++;
    if (n !== (DBZ ? 1 : N + 1)) begin
      failures++;
      $display("FAIL dbz_latency got %0d exp %0d", n, DBZ ? 1 : N + 1);
    end
    checks++;
    if (resp_quot !== 8'd255 || resp_rem !== 8'd42 || resp_dbz !== DBZ) begin
      failures++;
      $display("FAIL dbz_result got quot=%0d rem=%0d dbz=%b exp quot=255 rem=42 dbz=%b", resp_quot, resp_rem, resp_dbz, DBZ);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int n;
    bit bad;
    tick();
    set_req(2, 100, 7);
    req_valid = 4'b0100;
    @(negedge clk);
    sb.push_back(model(2, 100, 7));
    tick();
    req_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_dbz} !== '0) begin
      failures++;
      $display("FAIL midop_reset got valid=%b id=%0d quot=%0d rem=%0d dbz=%b exp all 0",
               resp_valid, resp_id, resp_quot, resp_rem, resp_dbz);
    end
    tick();
    rst = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midop_stale got resp_valid=1 exp no response");
    end
    tick();
    for (int i = 0; i < R; i++) set_req(i, 90 + i, 4 + i);
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midop_grant got %b exp 0001", req_ready);
    end
    sb.push_back(model(0, 90, 4));
    tick();
    req_valid = '0;
    wait_resp(n);
    checks++;
    if (!resp_valid) begin
      failures++;
      $display("FAIL midop_timeout got no resp_valid exp resp_valid=1");
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_boundary();
    test_div_zero();
    test_reset_midop();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 The module SHALL have parameter N, default 8: dividend/divisor/quotient/remainder width in bits (N >= 2).
REQ-002 The module SHALL have parameter R, default 4: number of requesters (R >= 2).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port req_valid  input  R  per-requester request strobe.
REQ-006 The module SHALL have port req_x  input  R*N  packed dividends; requester i occupies bits [i*N +: N].
REQ-007 The module SHALL have port req_y  input  R*N  packed divisors, packed the same way as req_x.
REQ-008 The module SHALL have port req_ready  output  R  one-hot grant/accept; at most one bit high.
REQ-009 The module SHALL have port resp_valid  output  1  result available.
REQ-010 The module SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 The module SHALL have port resp_id  output  $clog2(R)  index of the requester that owns the result.
REQ-012 The module SHALL have ports resp_quot and resp_rem  output  N each  unsigned quotient and remainder.
REQ-013 The module SHALL have port resp_dbz  output  1  divide-by-zero flag.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE with any req_valid high, req_ready SHALL go high for exactly one requester: the first requester with req_valid high, searching upward from rr_ptr with wrap-around.
REQ-016 A request SHALL be accepted in any cycle where req_valid[i] and req_ready[i] are both high; on acceptance the block latches X, Y and the index, and moves to BUSY.
REQ-017 On acceptance, rr_ptr SHALL become (granted index + 1) mod R.
REQ-018 In BUSY and DONE, req_ready SHALL be all zeros.
REQ-019 BUSY SHALL last exactly N cycles, with an internal counter running 0..N-1 and producing one quotient bit per cycle using unsigned restoring division.
REQ-020 Each BUSY step SHALL shift the {rem, quot} pair left by one, then trial-subtract Y from the upper half; if the result is negative, the upper half is restored and the quotient LSB is 0, otherwise the difference is kept and the quotient LSB is 1.
REQ-021 The trial subtraction SHALL be N+1 bits wide, so results are correct over the full unsigned range (no sign-bit aliasing).
REQ-022 After the final BUSY cycle (count == N-1) the FSM SHALL enter DONE; latency from acceptance edge to resp_valid high SHALL be N+1 cycles.
REQ-023 In DONE, resp_valid SHALL be 1 and resp_id, resp_quot, resp_rem and resp_dbz SHALL stay stable until resp_ready is high.
REQ-024 When resp_valid and resp_ready are both high, the FSM SHALL return to IDLE; the earliest next acceptance SHALL be the following cycle.
REQ-025 Outside DONE, resp_valid SHALL be 0; the resp_* data outputs SHALL hold their last values.
REQ-026 A requester that drops req_valid before it is granted SHALL lose nothing, because the block latches no state for ungranted requesters.
REQ-027 req_ready SHALL be a combinational function of state, rr_ptr and req_valid only, and SHALL NOT depend on resp_ready.

Reset
REQ-028 On rst low, the block SHALL immediately set state to IDLE, rr_ptr to 0, the counter to 0, resp_valid to 0, and resp_id, resp_quot, resp_rem and resp_dbz to 0.
REQ-029 A reset asserted during BUSY or DONE SHALL discard the operation in flight; no response for it is ever issued.

Configuration
REQ-030 With macro DIV_SCHEDULER_DBZ_EN defined, an accepted request with Y == 0 SHALL skip BUSY and enter DONE on the next cycle (latency 1), with resp_quot = all ones, resp_rem = X and resp_dbz = 1.
REQ-031 Without DIV_SCHEDULER_DBZ_EN, a Y == 0 request SHALL run the normal N-cycle sequence, and resp_dbz SHALL be tied to 0.

Structure
REQ-032 Package div_sched_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the state-width localparam.
REQ-033 Round-robin selection SHALL live in sub-module rr_arbiter (parameter R; inputs req and ptr; output one-hot grant); the divide datapath SHALL stay inline.

Verification
REQ-034 Single request: N=8, requester 2 sends X=100, Y=7 -> req_ready[2] high the same cycle; resp_valid 9 cycles later with id=2, quot=14, rem=2.
REQ-035 Fairness: all 4 requesters held valid continuously, rr_ptr=0 after reset -> grant order 0,1,2,3,0; each result matches its operands.
REQ-036 Backpressure: resp_ready held low 5 cycles during DONE -> resp_* stable; no req_ready asserted; IDLE is reached one cycle after resp_ready rises.
REQ-037 Boundary operands: X=255, Y=1 -> quot=255, rem=0; X=3, Y=255 -> quot=0, rem=3; X=255, Y=255 -> quot=1, rem=0.
REQ-038 Divide by zero: X=42, Y=0 -> with DIV_SCHEDULER_DBZ_EN defined, resp_valid after 1 cycle with quot=255, rem=42, dbz=1; without the macro, resp_valid after 9 cycles with dbz=0.
REQ-039 Reset mid-op: rst pulsed low during BUSY cycle 4 -> all outputs 0 immediately; no response issued; the next grant goes to requester 0 first.
